// File: rtl/sng_pkg.sv
// Shared defaults and state encoding for the dual stochastic number generator.
package sng_pkg;

    localparam int unsigned SNG_WIDTH     = 8;
    localparam int unsigned SNG_FRAME_LEN = 256;
    localparam int unsigned SNG_CNT_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } sng_state_e;

endpackage

// File: rtl/sng_chan.sv
// One stochastic channel: probability latch, registered compare, ones counter.
module sng_chan
    import sng_pkg::*;
#(
    parameter int unsigned WIDTH = SNG_WIDTH,
    parameter int unsigned CNT_W = SNG_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] rnd,
    output logic             s,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] x_q, x_d;
    logic             s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        x_d   = x_q;
        s_d   = 1'b0;
        cnt_d = cnt_q;
        if (run) begin
            s_d = (rnd < x_q);
        end
        if (valid && s_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // a new frame's latch and counter clear win over any stale count
        if (load) begin
            x_d   = x;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            s_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign s   = s_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/sng_frame_dual.sv
// Frame sequencer for two stochastic channels; drives LFSR reseed/advance.
module sng_frame_dual
    import sng_pkg::*;
#(
    parameter int unsigned WIDTH     = SNG_WIDTH,
    parameter int unsigned FRAME_LEN = SNG_FRAME_LEN,
    parameter int unsigned CNT_W     = SNG_CNT_W
) (
    input  logic             TRIG,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    input  logic [WIDTH-1:0] RND1,
    input  logic [WIDTH-1:0] RND2,
    output logic             LFSR_INIT,
    output logic             LFSR_EN,
    output logic             S1,
    output logic             S2,
    output logic             S_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2
);

    sng_state_e       state_q, state_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             lfsr_init_q, lfsr_init_d;
    logic             lfsr_en_q, lfsr_en_d;
    logic             s_valid_q, s_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c;
    logic             run_c;

    // next state, frame counter, and outputs decoded from the state being entered
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        load_c      = 1'b0;
        run_c       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    load_c  = 1'b1;
                    frame_d = '0;
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEED: state_d = ST_RUN;
            ST_RUN: begin
                run_c   = 1'b1;
                frame_d = frame_q + CNT_W'(1);
                if (frame_q == CNT_W'(FRAME_LEN - 1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        lfsr_init_d = (state_d == ST_SEED);
        lfsr_en_d   = (state_d == ST_RUN);
        busy_d      = (state_d == ST_SEED) || (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d      = (state_d == ST_DONE);
        s_valid_d   = run_c;
    end

    always_ff @(posedge TRIG or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            lfsr_init_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            lfsr_init_q <= lfsr_init_d;
            lfsr_en_q   <= lfsr_en_d;
            s_valid_q   <= s_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    sng_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan1 (
        .clk   (TRIG),
        .rst_n (RESET),
        .load  (load_c),
        .run   (run_c),
        .valid (s_valid_q),
        .x     (X1),
        .rnd   (RND1),
        .s     (S1),
        .cnt   (CNT1)
    );

    sng_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan2 (
        .clk   (TRIG),
        .rst_n (RESET),
        .load  (load_c),
        .run   (run_c),
        .valid (s_valid_q),
        .x     (X2),
        .rnd   (RND2),
        .s     (S2),
        .cnt   (CNT2)
    );

    assign LFSR_INIT = lfsr_init_q;
    assign LFSR_EN   = lfsr_en_q;
    assign S_VALID   = s_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
